// File: rtl/coder_arb_pkg.sv
// Shared types and constants for the coder output arbiter.
package coder_arb_pkg;

  typedef enum logic [1:0] {
    ARB_RUN,
    ARB_DRAIN,
    ARB_DONE
  } arb_state_e;

  localparam int unsigned ARB_STAT_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping from N-1 to 0. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int unsigned N = 8,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any
);

  logic [31:0]  cand;
  logic [W-1:0] cand_idx;

  // Scan requesters starting at ptr; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = {{(32 - W){1'b0}}, ptr} + i;
      if (cand >= N) cand = cand - N;
      cand_idx = cand[W-1:0];
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/coder_out_arbiter.sv
// Merges the per-lane arithmetic coder byte streams into one tagged output stream
// through a single-stage output register. bits_last marks only the final byte of
// the whole compressed output, i.e. the last byte of the last lane to finish.
// Optional feature: define CODER_ARB_STATS_EN for per-lane accepted-byte counters
// on the stat_bytes port.
module coder_out_arbiter
  import coder_arb_pkg::*;
#(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned IDX_W     = 8,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                        coder_clk,
  input  logic                        coder_rst,
  input  logic [NUM_LANES-1:0]        lane_valid,
  output logic [NUM_LANES-1:0]        lane_ready,
  input  logic [NUM_LANES*DATA_W-1:0] lane_byte,
  input  logic [NUM_LANES-1:0]        lane_last,
  output logic                        coder_out_valid,
  input  logic                        coder_out_ready,
  output logic [IDX_W-1:0]            coder_out_bits_idx,
  output logic [DATA_W-1:0]           coder_out_bits_byte,
  output logic                        coder_out_bits_last,
  output logic                        status_done
`ifdef CODER_ARB_STATS_EN
  ,
  output logic [NUM_LANES*ARB_STAT_W-1:0] stat_bytes
`endif
);

  localparam int unsigned PTR_W = $clog2(NUM_LANES);

  arb_state_e           state_q, state_d;
  logic [NUM_LANES-1:0] done_q, done_d;
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic                 out_valid_q, out_valid_d;
  logic [IDX_W-1:0]     out_idx_q, out_idx_d;
  logic [DATA_W-1:0]    out_byte_q, out_byte_d;
  logic                 out_last_q, out_last_d;

  logic [NUM_LANES-1:0] req;
  logic [NUM_LANES-1:0] grant;
  logic [PTR_W-1:0]     grant_idx;
  logic                 any_eligible;
  logic                 load;
  logic                 hs_out;
  logic                 grant_last;
  logic [DATA_W-1:0]    grant_byte;

  // Finished lanes and all lanes outside RUN are excluded from arbitration.
  assign req = (state_q == ARB_RUN) ? (lane_valid & ~done_q) : '0;

  rr_arbiter #(
    .N(NUM_LANES)
  ) u_rr_arbiter (
    .req      (req),
    .ptr      (rr_q),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any      (any_eligible)
  );

  // Reset gates load so no lane is accepted while coder_rst is high.
  assign load       = ~coder_rst & (state_q == ARB_RUN) & (~out_valid_q | coder_out_ready) &
                      any_eligible;
  assign lane_ready = load ? grant : '0;
  assign hs_out     = out_valid_q & coder_out_ready;

  // Stream-final only if the granted lane's last closes the final open lane.
  assign grant_last = (|(grant & lane_last)) & (&(done_q | grant));

  // Select the granted lane's byte; one-hot grant, so at most one term is live.
  always_comb begin
    grant_byte = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (grant[i]) grant_byte = lane_byte[i*DATA_W +: DATA_W];
    end
  end

  // Next-state: FSM, lane-done flags, round-robin pointer and output register.
  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_byte_d  = out_byte_q;
    out_last_d  = out_last_q;

    case (state_q)
      ARB_RUN:   if (load && grant_last) state_d = ARB_DRAIN;
      ARB_DRAIN: if (hs_out) state_d = ARB_DONE;
      ARB_DONE:  state_d = ARB_DONE;
      default:   state_d = ARB_RUN;
    endcase

    if (load) begin
      done_d      = done_q | (grant & lane_last);
      rr_d        = (grant_idx == PTR_W'(NUM_LANES - 1)) ? '0 : grant_idx + 1'b1;
      out_valid_d = 1'b1;
      out_idx_d   = IDX_W'(grant_idx);
      out_byte_d  = grant_byte;
      out_last_d  = grant_last;
    end else if (hs_out) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; a pending output beat is dropped.
  always_ff @(posedge coder_clk) begin
    if (coder_rst) begin
      state_q     <= ARB_RUN;
      done_q      <= '0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_byte_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_byte_q  <= out_byte_d;
      out_last_q  <= out_last_d;
    end
  end

  assign coder_out_valid     = out_valid_q;
  assign coder_out_bits_idx  = out_idx_q;
  assign coder_out_bits_byte = out_byte_q;
  assign coder_out_bits_last = out_last_q;
  assign status_done         = (state_q == ARB_DONE);

`ifdef CODER_ARB_STATS_EN
  logic [ARB_STAT_W-1:0] stat_q [NUM_LANES];

  // Per-lane accepted-byte counters; wrap naturally at 2^32.
  always_ff @(posedge coder_clk) begin
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (coder_rst) begin
        stat_q[i] <= '0;
      end else if (lane_ready[i]) begin
        stat_q[i] <= stat_q[i] + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < int'(NUM_LANES); gi++) begin : g_stat
    assign stat_bytes[gi*ARB_STAT_W +: ARB_STAT_W] = stat_q[gi];
  end
`endif

endmodule

// File: tb/tb_coder_out_arbiter.sv
// Self-checking bench for coder_out_arbiter: directed table, hand sequences for
// fairness / last ordering / mid-stream reset, and randomized traffic against a
// cycle-level reference model.
module tb_coder_out_arbiter;

  localparam int NL = 8;
  localparam int DW = 8;
  localparam int IW = 8;

  logic             coder_clk = 1'b0;
  logic             coder_rst = 1'b1;
  logic [NL-1:0]    lane_valid = '0;
  logic [NL-1:0]    lane_ready;
  logic [NL*DW-1:0] lane_byte = '0;
  logic [NL-1:0]    lane_last = '0;
  logic             coder_out_valid;
  logic             coder_out_ready = 1'b0;
  logic [IW-1:0]    coder_out_bits_idx;
  logic [DW-1:0]    coder_out_bits_byte;
  logic             coder_out_bits_last;
  logic             status_done;
`ifdef CODER_ARB_STATS_EN
  logic [NL*32-1:0] stat_bytes;
`endif

  coder_out_arbiter #(
    .NUM_LANES(NL),
    .IDX_W    (IW),
    .DATA_W   (DW)
  ) dut (
    .coder_clk          (coder_clk),
    .coder_rst          (coder_rst),
    .lane_valid         (lane_valid),
    .lane_ready         (lane_ready),
    .lane_byte          (lane_byte),
    .lane_last          (lane_last),
    .coder_out_valid    (coder_out_valid),
    .coder_out_ready    (coder_out_ready),
    .coder_out_bits_idx (coder_out_bits_idx),
    .coder_out_bits_byte(coder_out_bits_byte),
    .coder_out_bits_last(coder_out_bits_last),
    .status_done        (status_done)
`ifdef CODER_ARB_STATS_EN
    ,
    .stat_bytes         (stat_bytes)
`endif
  );

  always #5 coder_clk = ~coder_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = running, 1 = final beat pending, 2 = finished.
  int          m_phase = 0;
  int          m_rr = 0;
  logic [7:0]  m_closed = '0;
  bit          m_ov = 0;
  int          m_idx = 0;
  logic [7:0]  m_byte = '0;
  bit          m_last = 0;
  int unsigned m_stat [NL];
  bit          mdl_on = 0;

  // Lane the spec rules would accept this cycle, or -1.
  function automatic int m_pick();
    if (coder_rst || m_phase != 0 || (m_ov && !coder_out_ready)) return -1;
    for (int k = 0; k < NL; k++) begin
      int j;
      j = (m_rr + k) % NL;
      if (lane_valid[j] && !m_closed[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_update();
    int g;
    bit hs;
    if (coder_rst) begin
      m_phase = 0; m_rr = 0; m_closed = '0; m_ov = 0;
      m_idx = 0; m_byte = '0; m_last = 0;
      for (int i = 0; i < NL; i++) m_stat[i] = 0;
      return;
    end
    g  = m_pick();
    hs = m_ov && coder_out_ready;
    if (m_phase == 1 && hs) m_phase = 2;
    if (g >= 0) begin
      if (lane_last[g]) m_closed[g] = 1'b1;
      m_last = lane_last[g] && (m_closed == 8'hFF);
      m_ov   = 1;
      m_idx  = g;
      m_byte = lane_byte[g*DW +: DW];
      m_rr   = (g + 1) % NL;
      m_stat[g]++;
      if (m_last) m_phase = 1;
    end else if (hs) begin
      m_ov = 0;
    end
  endtask

  // Compare DUT against the model mid-cycle, then advance one clock.
  task automatic tick();
    int g;
    #1;
    if (mdl_on) begin
      g = m_pick();
      chk("model_lane_ready", lane_ready, (g < 0) ? 8'h00 : (8'h01 << g));
      chk("model_out_valid", coder_out_valid, m_ov);
      chk("model_idx", coder_out_bits_idx, m_idx);
      chk("model_byte", coder_out_bits_byte, m_byte);
      chk("model_last", coder_out_bits_last, m_last);
      chk("model_status_done", status_done, m_phase == 2);
`ifdef CODER_ARB_STATS_EN
      for (int i = 0; i < NL; i++) chk("model_stat", stat_bytes[i*32 +: 32], m_stat[i]);
`endif
    end
    @(posedge coder_clk);
    model_update();
    @(negedge coder_clk);
  endtask

  typedef struct packed {
    logic       rst;
    logic [7:0] valid;
    logic       ready;
    logic [7:0] exp_lr;
    logic       exp_ov;
    logic [7:0] exp_idx;
  } vec_t;

  vec_t tbl [14];

  int  rem   [NL];
  int  beats [NL];
  int  n_last, last_idx;
  bit  lane3_closed, saw_ready3, fin, done_seen;
  int  exp_idx;

  initial begin
    tbl[0]  = '{1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 8'hFF, 1'b1, 8'h01, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 8'hFF, 1'b1, 8'h02, 1'b1, 8'd0};
    tbl[5]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 8'd1};
    tbl[6]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 8'd1};
    tbl[7]  = '{1'b0, 8'hFF, 1'b1, 8'h04, 1'b1, 8'd1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'd2};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'd2};
    tbl[10] = '{1'b0, 8'h80, 1'b1, 8'h80, 1'b0, 8'd2};
    tbl[11] = '{1'b0, 8'h01, 1'b1, 8'h01, 1'b1, 8'd7};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'd0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'd0};

    for (int i = 0; i < NL; i++) lane_byte[i*DW +: DW] = 8'hA0 + 8'(i);

    @(posedge coder_clk);
    model_update();
    @(negedge coder_clk);
    mdl_on = 1;

    // Directed table: reset hold, first beats, backpressure, wrap-around.
    for (int r = 0; r < 14; r++) begin
      coder_rst       = tbl[r].rst;
      lane_valid      = tbl[r].valid;
      coder_out_ready = tbl[r].ready;
      #1;
      chk("tbl_lane_ready", lane_ready, tbl[r].exp_lr);
      chk("tbl_out_valid", coder_out_valid, tbl[r].exp_ov);
      if (tbl[r].exp_ov) begin
        chk("tbl_idx", coder_out_bits_idx, tbl[r].exp_idx);
        chk("tbl_byte", coder_out_bits_byte, 8'hA0 + tbl[r].exp_idx);
      end
      tick();
    end

    // Fairness: every lane busy, sink always ready.
    coder_rst = 1'b1;
    tick();
    coder_rst       = 1'b0;
    lane_valid      = 8'hFF;
    lane_last       = '0;
    coder_out_ready = 1'b1;
    exp_idx         = 0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (c >= 1) begin
        chk("fair_valid", coder_out_valid, 1'b1);
        chk("fair_idx", coder_out_bits_idx, exp_idx);
        exp_idx = (exp_idx + 1) % NL;
      end
      tick();
    end

    // Last ordering: lanes 0..6 send 2 bytes, lane 7 sends 4; lane 3 stays valid after closing.
    coder_rst = 1'b1;
    tick();
    coder_rst = 1'b0;
    for (int i = 0; i < NL; i++) begin
      rem[i]   = (i == 7) ? 4 : 2;
      beats[i] = 0;
    end
    n_last = 0; last_idx = -1;
    lane3_closed = 0; saw_ready3 = 0; fin = 0; done_seen = 0;
    for (int c = 0; c < 200 && !done_seen; c++) begin
      for (int i = 0; i < NL; i++) begin
        lane_valid[i]        = (rem[i] > 0) || (i == 3 && lane3_closed);
        lane_last[i]         = (rem[i] == 1);
        lane_byte[i*DW +: DW] = 8'($urandom);
      end
      coder_out_ready = 1'b1;
      #1;
      if (fin) begin
        chk("done_after_last", status_done, 1'b1);
        done_seen = 1;
      end else begin
        chk("done_early", status_done, 1'b0);
      end
      if (lane3_closed && lane_ready[3]) saw_ready3 = 1;
      if (coder_out_valid && coder_out_ready) begin
        beats[coder_out_bits_idx]++;
        if (coder_out_bits_last) begin
          n_last++;
          last_idx = int'(coder_out_bits_idx);
          fin = 1;
        end
      end
      for (int i = 0; i < NL; i++) begin
        if (lane_ready[i] && rem[i] > 0) begin
          rem[i]--;
          if (i == 3 && rem[i] == 0) lane3_closed = 1;
        end
      end
      tick();
    end
    chk("drain_timeout", done_seen, 1'b1);
    chk("last_count", n_last, 1);
    chk("last_idx", last_idx, 7);
    for (int i = 0; i < NL; i++) chk("lane_beats", beats[i], (i == 7) ? 4 : 2);
    chk("closed_lane3_ready", saw_ready3, 1'b0);

    // Mid-stream reset with a pending beat and a closed lane.
    coder_rst = 1'b1;
    tick();
    coder_rst       = 1'b0;
    lane_valid      = 8'hFF;
    lane_last       = 8'h08;
    coder_out_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    coder_out_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("pending_before_rst", coder_out_valid, 1'b1);
    coder_rst = 1'b1;
    tick();
    coder_rst       = 1'b0;
    lane_valid      = 8'hFF;
    lane_last       = '0;
    coder_out_ready = 1'b1;
    #1;
    chk("rst_drop_valid", coder_out_valid, 1'b0);
    chk("rst_rr_cleared", lane_ready, 8'h01);
`ifdef CODER_ARB_STATS_EN
    for (int i = 0; i < NL; i++) chk("rst_stat_zero", stat_bytes[i*32 +: 32], 0);
`endif
    tick();
    lane_valid = 8'h08;
    #1;
    chk("rst_done_cleared", lane_ready, 8'h08);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      coder_rst       = ($urandom_range(0, 199) == 0);
      lane_valid      = 8'($urandom);
      lane_last       = 8'($urandom & $urandom & $urandom & $urandom);
      coder_out_ready = ($urandom_range(0, 3) != 0);
      lane_byte       = {$urandom, $urandom};
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
